bpsk_demodulator: RTL

//  Receive-side counterpart of the BPSK modulator. Coherently correlates

---
 rtl/bpsk_demodulator_pkg.sv | 17 +
 rtl/bpsk_demodulator_if.sv | 38 +++
 rtl/bpsk_demodulator_correlator.sv | 81 ++++++++
 rtl/bpsk_demodulator.sv | 123 ++++++++++++
 4 files changed

// File: rtl/bpsk_demodulator_pkg.sv
// Shared types and width helpers for the BPSK demodulator.
// Bit order on the wire is LSB first: bit k of a word is the k-th bit sliced.
package bpsk_demodulator_pkg;

    // Demodulator control states, also exported on the debug port
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Correlation accumulator width: full product plus one bit per doubling of
    // the integration length, so a full carrier period can never overflow
    function automatic int acc_width(input int sample_width, input int sample_number);
        return 2 * sample_width + $clog2(sample_number);
    endfunction

endpackage

// File: rtl/bpsk_demodulator_if.sv
// Sample-in / bit-and-word-out bundle of the BPSK demodulator.
//
// Handshake: en qualifies rx_sample, ref_sine and cnt_in in the same cycle.
// There is no backpressure; every cycle with en=1 presents one sample and the
// demodulator decides internally whether to integrate it. bit_valid and
// data_valid are single-cycle strobes marking bit_out / data_out as new; the
// consumer must take them in that cycle. state is a debug view of the FSM.
interface bpsk_demodulator_if #(
    parameter int SAMPLE_NUMBER = 256,
    parameter int SAMPLE_WIDTH  = 12,
    parameter int DATA_WIDTH    = 12
);
    import bpsk_demodulator_pkg::*;

    localparam int CNT_W = $clog2(SAMPLE_NUMBER);

    logic                    en;
    logic [SAMPLE_WIDTH-1:0] rx_sample;
    logic [SAMPLE_WIDTH-1:0] ref_sine;
    logic [CNT_W-1:0]        cnt_in;
    logic                    bit_out;
    logic                    bit_valid;
    logic [DATA_WIDTH-1:0]   data_out;
    logic                    data_valid;
    logic                    busy;
    state_t                  state;

    modport master (
        output en, rx_sample, ref_sine, cnt_in,
        input  bit_out, bit_valid, data_out, data_valid, busy, state
    );

    modport slave (
        input  en, rx_sample, ref_sine, cnt_in,
        output bit_out, bit_valid, data_out, data_valid, busy, state
    );

endinterface

// File: rtl/bpsk_demodulator_correlator.sv
// Coherent correlator: offset removal, signed multiply against the reference
// sine, integrate-and-dump over one carrier period, and sign slicing.
// The slice result is combinational; the top level registers it.
module bpsk_demodulator_correlator
    import bpsk_demodulator_pkg::*;
#(
    parameter int SAMPLE_NUMBER = 256,
    parameter int SAMPLE_WIDTH  = 12
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             accept,
    input  logic                             flush,
    input  logic [SAMPLE_WIDTH-1:0]          rx_sample,
    input  logic [SAMPLE_WIDTH-1:0]          ref_sine,
    input  logic [$clog2(SAMPLE_NUMBER)-1:0] cnt_in,
    output logic                             slice_valid,
    output logic                             slice_bit
);
    localparam int CNT_W  = $clog2(SAMPLE_NUMBER);
    localparam int PROD_W = 2 * SAMPLE_WIDTH;
    localparam int ACC_W  = acc_width(SAMPLE_WIDTH, SAMPLE_NUMBER);

    localparam logic [SAMPLE_WIDTH-1:0] MIDSCALE = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0]        LAST_IDX = CNT_W'(SAMPLE_NUMBER - 1);

    logic signed [SAMPLE_WIDTH-1:0] s;
    logic signed [SAMPLE_WIDTH-1:0] r;
    logic signed [PROD_W-1:0]       prod;
    logic signed [PROD_W-1:0]       prod_d, prod_q;
    logic                           valid_d, valid_q;
    logic                           last_d, last_q;
    logic signed [ACC_W-1:0]        acc_d, acc_q;
    logic signed [ACC_W-1:0]        acc_sum;

    // Stage 1: remove the mid-scale offset and form the signed product
    always_comb begin
        s       = $signed(rx_sample - MIDSCALE);
        r       = $signed(ref_sine - MIDSCALE);
        prod    = PROD_W'(s) * PROD_W'(r);
        valid_d = accept;
        last_d  = accept && (cnt_in == LAST_IDX);
        prod_d  = accept ? prod : '0;
    end

    // Stage 2: integrate, dump on the last sample of the period, slice on sign.
    // After a dump acc is zero, so the next product loads it directly.
    always_comb begin
        acc_sum     = acc_q + ACC_W'(prod_q);
        acc_d       = acc_q;
        slice_valid = 1'b0;
        slice_bit   = 1'b0;
        if (flush) begin
            acc_d = '0;
        end else if (valid_q) begin
            if (last_q) begin
                acc_d       = '0;
                slice_valid = 1'b1;
                slice_bit   = ~acc_sum[ACC_W-1];
            end else begin
                acc_d = acc_sum;
            end
        end
    end

    // Pipeline and accumulator registers; flush also empties stage 1
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            acc_q   <= '0;
        end else begin
            prod_q  <= prod_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: rtl/bpsk_demodulator.sv
// BPSK demodulator top: IDLE/RUN control, bit counter, LSB-first word
// assembly and the registered bit/word outputs around the correlator.
module bpsk_demodulator
    import bpsk_demodulator_pkg::*;
#(
    parameter int SAMPLE_NUMBER = 256,
    parameter int SAMPLE_WIDTH  = 12,
    parameter int DATA_WIDTH    = 12
) (
    input  logic              clk,
    input  logic              rst,
    bpsk_demodulator_if.slave bus
);
    localparam int CNT_W = $clog2(SAMPLE_NUMBER);
    localparam int BC_W  = $clog2(DATA_WIDTH);

    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_WIDTH - 1);

    state_t                state_d, state_q;
    logic [BC_W-1:0]       bit_cnt_d, bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_d, shift_q;
    logic                  bit_out_d, bit_out_q;
    logic                  bit_valid_d, bit_valid_q;
    logic [DATA_WIDTH-1:0] data_out_d, data_out_q;
    logic                  data_valid_d, data_valid_q;

    logic accept;
    logic flush;
    logic slice_valid;
    logic slice_bit;

    // Integration only ever starts on a period boundary; leaving RUN flushes
    always_comb begin
        accept = bus.en && ((state_q == ST_RUN) || (bus.cnt_in == '0));
        flush  = (state_q == ST_RUN) && !bus.en;
    end

    bpsk_demodulator_correlator #(
        .SAMPLE_NUMBER (SAMPLE_NUMBER),
        .SAMPLE_WIDTH  (SAMPLE_WIDTH)
    ) u_correlator (
        .clk         (clk),
        .rst         (rst),
        .accept      (accept),
        .flush       (flush),
        .rx_sample   (bus.rx_sample),
        .ref_sine    (bus.ref_sine),
        .cnt_in      (bus.cnt_in[CNT_W-1:0]),
        .slice_valid (slice_valid),
        .slice_bit   (slice_bit)
    );

    // Next-state: FSM transitions, word assembly and output strobes
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        bit_out_d    = bit_out_q;
        bit_valid_d  = 1'b0;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.en) begin
                    // Abandon the partial word; data_out keeps the last good word
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // slice_valid is already suppressed by flush, so this never fights the abort
        if (slice_valid) begin
            bit_out_d   = slice_bit;
            bit_valid_d = 1'b1;
            shift_d     = {slice_bit, shift_q[DATA_WIDTH-1:1]};
            if (bit_cnt_q == LAST_BIT) begin
                data_out_d   = shift_d;
                data_valid_d = 1'b1;
                bit_cnt_d    = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            bit_out_q    <= 1'b0;
            bit_valid_q  <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            bit_out_q    <= bit_out_d;
            bit_valid_q  <= bit_valid_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign bus.bit_out    = bit_out_q;
    assign bus.bit_valid  = bit_valid_q;
    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.busy       = (state_q == ST_RUN);
    assign bus.state      = state_q;

endmodule
